// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus among N_REQ execution-unit result ports.
// Define CDB_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module cdb_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TAG_W     = 4,
  parameter int ROB_DEPTH = 16,
  parameter int ROB_PTR_W = $clog2(ROB_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [N_REQ-1:0]           exu_req,
  output logic [N_REQ-1:0]           exu_rdy,
  input  logic [N_REQ*TAG_W-1:0]     exu_tag,
  input  logic [N_REQ*32-1:0]        exu_wdata,
  input  logic [N_REQ*ROB_PTR_W-1:0] exu_inst_id,
  output logic                       cdb_wr,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [31:0]                cdb_wdata,
  output logic [ROB_PTR_W-1:0]       cdb_inst_id
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]     gnt_s;
  logic [PTR_W-1:0]     gnt_idx_s;
  logic                 gnt_vld_s;

  logic                 wr_q, wr_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [ROB_PTR_W-1:0] inst_id_q, inst_id_d;

`ifdef CDB_RR_EN
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  int                   scan_idx_s;

  // Round-robin grant: scan upward from rr_ptr, wrapping at N_REQ.
  always_comb begin
    gnt_s      = '0;
    gnt_idx_s  = '0;
    gnt_vld_s  = 1'b0;
    scan_idx_s = 0;
    if (flush) begin
      gnt_vld_s = 1'b0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_idx_s = (int'(rr_ptr_q) + k) % N_REQ;
        if (!gnt_vld_s && exu_req[scan_idx_s]) begin
          gnt_s[scan_idx_s] = 1'b1;
          gnt_idx_s         = PTR_W'(scan_idx_s);
          gnt_vld_s         = 1'b1;
        end else begin
          gnt_vld_s = gnt_vld_s;
        end
      end
    end
  end

  // Pointer moves just past the winner; it holds when nothing transfers.
  always_comb begin
    if (gnt_vld_s) begin
      if (gnt_idx_s == PTR_W'(N_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx_s + PTR_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority grant: lowest requesting index wins.
  always_comb begin
    gnt_s     = '0;
    gnt_idx_s = '0;
    gnt_vld_s = 1'b0;
    if (flush) begin
      gnt_vld_s = 1'b0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!gnt_vld_s && exu_req[k]) begin
          gnt_s[k]  = 1'b1;
          gnt_idx_s = PTR_W'(k);
          gnt_vld_s = 1'b1;
        end else begin
          gnt_vld_s = gnt_vld_s;
        end
      end
    end
  end
`endif

  // Capture the winner's payload; only the granted port is ever selected.
  always_comb begin
    wr_d = gnt_vld_s;
    if (gnt_vld_s) begin
      tag_d     = exu_tag[int'(gnt_idx_s)*TAG_W +: TAG_W];
      wdata_d   = exu_wdata[int'(gnt_idx_s)*32 +: 32];
      inst_id_d = exu_inst_id[int'(gnt_idx_s)*ROB_PTR_W +: ROB_PTR_W];
    end else begin
      tag_d     = tag_q;
      wdata_d   = wdata_q;
      inst_id_d = inst_id_q;
    end
  end

  // Broadcast register; reset dominates flush and any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= 1'b0;
      tag_q     <= '0;
      wdata_q   <= 32'h0000_0000;
      inst_id_q <= '0;
    end else begin
      wr_q      <= wr_d;
      tag_q     <= tag_d;
      wdata_q   <= wdata_d;
      inst_id_q <= inst_id_d;
    end
  end

  assign exu_rdy     = gnt_s;
  assign cdb_wr      = wr_q & ~flush;
  assign cdb_tag     = tag_q;
  assign cdb_wdata   = wdata_q;
  assign cdb_inst_id = inst_id_q;

endmodule
